// File: rtl/tessia_ctrl_pkg.sv
// Shared encodings, control bundle and FSM states for the TessiaV1 control decoder.
package tessia_ctrl_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] CMD_MUL = 4'b0000;
    localparam logic [3:0] CMD_DIV = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_MOD = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_MOD = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b0110;
    localparam logic [3:0] ALU_DIV = 4'b1000;

    typedef struct packed {
        logic [1:0] reg_src;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB
    } mc_state_t;

    function automatic logic is_mc_alu(input logic [3:0] alu_control);
        return (alu_control == ALU_MUL) || (alu_control == ALU_DIV) || (alu_control == ALU_MOD);
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational main + ALU decode; reg_w in the bundle is already gated
// by compare-only and undefined-command conditions.
module decode_comb
    import tessia_ctrl_pkg::*;
(
    input  logic [1:0]   op,
    input  logic [5:0]   funct,
    output ctrl_bundle_t ctrl,
    output logic [3:0]   alu_control,
    output logic [1:0]   flag_w,
    output logic         no_write
);

    ctrl_bundle_t main_ctrl;
    logic [3:0]   cmd;
    logic         undef_cmd;
    logic         arith;

    assign cmd = funct[4:1];

    always_comb begin
        main_ctrl = '0;
        case (op)
            OP_DP: begin
                main_ctrl.alu_src = funct[5];
                main_ctrl.reg_w   = 1'b1;
                main_ctrl.alu_op  = 1'b1;
            end
            OP_MEM: begin
                main_ctrl.imm_src = 2'b01;
                main_ctrl.alu_src = 1'b1;
                if (funct[0]) begin
                    main_ctrl.mem_to_reg = 1'b1;
                    main_ctrl.reg_w      = 1'b1;
                end else begin
                    main_ctrl.reg_src = 2'b10;
                    main_ctrl.mem_w   = 1'b1;
                end
            end
            OP_BR: begin
                main_ctrl.reg_src = 2'b01;
                main_ctrl.imm_src = 2'b10;
                main_ctrl.alu_src = 1'b1;
                main_ctrl.branch  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = '0;
        flag_w      = '0;
        no_write    = 1'b0;
        undef_cmd   = 1'b0;
        arith       = 1'b0;
        if (op == OP_DP) begin
            case (cmd)
                CMD_ADD: begin alu_control = ALU_ADD; arith = 1'b1; end
                CMD_SUB: begin alu_control = ALU_SUB; arith = 1'b1; end
                CMD_CMP: begin alu_control = ALU_SUB; arith = 1'b1; no_write = 1'b1; end
                CMD_MUL: alu_control = ALU_MUL;
                CMD_ORR: alu_control = ALU_ORR;
                CMD_DIV: alu_control = ALU_DIV;
                CMD_MOD: alu_control = ALU_MOD;
                CMD_MOV: alu_control = ALU_MOV;
                default: undef_cmd = 1'b1;
            endcase
            flag_w = {funct[0], funct[0] & arith};
        end else if (op != OP_NOP) begin
            alu_control = funct[5] ? ALU_ADD : ALU_SUB;
        end
    end

    always_comb begin
        ctrl       = main_ctrl;
        ctrl.reg_w = main_ctrl.reg_w & ~no_write & ~undef_cmd;
    end

endmodule

// File: rtl/multicycle_decoder.sv
// TessiaV1 control decoder: single-cycle decode plus an IDLE/ISSUE/WAIT/WB
// handshake that stalls the front end while an external MUL/DIV/MOD unit runs.
module multicycle_decoder
    import tessia_ctrl_pkg::*;
#(
    parameter bit          MC_ENABLE  = 1'b1,
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = $clog2(MC_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       InstrValid,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MCDone,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] ALUControl,
    output logic       MCStart,
    output logic       Stall,
    output logic       MCTimeout
);

    ctrl_bundle_t     dec;
    logic [3:0]       dec_alu;
    logic [1:0]       dec_flag_w;
    logic             dec_no_write;

    mc_state_t        state, state_next;
    logic [CNT_W-1:0] cnt;
    ctrl_bundle_t     lat_ctrl;
    logic [3:0]       lat_alu;
    logic [1:0]       lat_flag_w;
    logic             lat_no_write;
    logic [3:0]       lat_rd;

    logic             is_mc;
    logic             accept;
    logic             cnt_last;
    logic             timeout_hit;

    decode_comb u_decode (
        .op          (Op),
        .funct       (Funct),
        .ctrl        (dec),
        .alu_control (dec_alu),
        .flag_w      (dec_flag_w),
        .no_write    (dec_no_write)
    );

    assign is_mc       = MC_ENABLE && (Op == OP_DP) && is_mc_alu(dec_alu);
    assign accept      = (state == ST_IDLE) && InstrValid && is_mc;
    assign cnt_last    = (cnt == CNT_W'(MC_TIMEOUT - 1));
    assign timeout_hit = (state == ST_WAIT) && !MCDone && cnt_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lat_ctrl     <= '0;
            lat_alu      <= '0;
            lat_flag_w   <= '0;
            lat_no_write <= 1'b0;
            lat_rd       <= '0;
            MCTimeout    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_ISSUE: cnt <= '0;
                ST_WAIT:  cnt <= cnt + CNT_W'(1);
                default:  ;
            endcase
            if (accept) begin
                lat_ctrl     <= dec;
                lat_alu      <= dec_alu;
                lat_flag_w   <= dec_flag_w;
                lat_no_write <= dec_no_write;
                lat_rd       <= Rd;
            end
            if (timeout_hit) begin
                MCTimeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        RegSrc     = dec.reg_src;
        ImmSrc     = dec.imm_src;
        ALUSrc     = dec.alu_src;
        MemtoReg   = dec.mem_to_reg;
        ALUControl = dec_alu;
        NoWrite    = dec_no_write;
        RegW       = InstrValid & dec.reg_w;
        MemW       = InstrValid & dec.mem_w;
        FlagW      = InstrValid ? dec_flag_w : 2'b00;
        PCS        = InstrValid & (((Rd == 4'hF) & dec.reg_w) | dec.branch);
        MCStart    = 1'b0;
        Stall      = 1'b0;

        // Once an op is in flight every datapath control comes from the latch
        // so the front end can change Op/Funct freely while stalled.
        if (state != ST_IDLE) begin
            RegSrc     = lat_ctrl.reg_src;
            ImmSrc     = lat_ctrl.imm_src;
            ALUSrc     = lat_ctrl.alu_src;
            MemtoReg   = lat_ctrl.mem_to_reg;
            ALUControl = lat_alu;
            NoWrite    = lat_no_write;
            RegW       = 1'b0;
            MemW       = 1'b0;
            FlagW      = 2'b00;
            PCS        = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ISSUE;
                    RegW       = 1'b0;
                    FlagW      = 2'b00;
                    PCS        = 1'b0;
                    Stall      = 1'b1;
                end
            end
            ST_ISSUE: begin
                MCStart    = 1'b1;
                Stall      = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                Stall = 1'b1;
                if (MCDone) begin
                    state_next = ST_WB;
                end else if (cnt_last) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WB: begin
                RegW       = lat_ctrl.reg_w & lat_ctrl.alu_op;
                FlagW      = lat_ctrl.alu_op ? lat_flag_w : 2'b00;
                MemW       = lat_ctrl.mem_w;
                PCS        = ((lat_rd == 4'hF) & RegW) | lat_ctrl.branch;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (!reset) begin
            RegW    = 1'b0;
            MemW    = 1'b0;
            PCS     = 1'b0;
            FlagW   = 2'b00;
            MCStart = 1'b0;
            Stall   = 1'b0;
        end
    end

endmodule
